// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter output path: sample format,
// buffer geometry and the capture state encoding.
package iir_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int FRAC_W    = 22;
  localparam int N_SAMPLES = 2048;
  localparam int IDX_W     = 11;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/iir_sample_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module iir_sample_ram #(
  parameter int W     = 24,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_r [DEPTH];

  // Storage array is left unreset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= W'(0);
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/iir_result_capture.sv
// Captures the IIR filter output stream into a sample buffer, tracking peak
// magnitude and output settling, with a synchronous readback port.
module iir_result_capture
  import iir_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int DEPTH      = N_SAMPLES,
  parameter int ADDR_W     = IDX_W,
  parameter int STABLE_TOL = 64,
  parameter int STABLE_RUN = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  input  logic                     filter_done,
  output logic [ADDR_W:0]          wr_count,
  output logic                     capturing,
  output logic                     capture_done,
  output logic                     overflow,
  output logic                     settled,
  output logic [ADDR_W-1:0]        settle_idx,
  output logic [DATA_W-1:0]        peak_abs,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid
);

  localparam int RUN_W = $clog2(STABLE_RUN + 1);
  localparam int CNT_W = ADDR_W + 1;

  cap_state_t               state_r;
  logic signed [DATA_W-1:0] prev_r;
  logic [RUN_W-1:0]         run_r;

  logic [DATA_W:0]   din_ext_s;
  logic [DATA_W:0]   delta_s;
  logic [DATA_W:0]   delta_abs_s;
  logic [DATA_W:0]   din_abs_ext_s;
  logic [DATA_W-1:0] din_abs_s;
  logic              still_s;
  logic              first_s;
  logic [RUN_W-1:0]  run_next_s;
  logic              reach_settle_s;
  logic              wr_en_s;
  logic              last_wr_s;

  // Magnitude, step size and stillness run for the incoming sample
  always_comb begin
    din_ext_s = {din[DATA_W-1], din};
    delta_s   = din_ext_s - {prev_r[DATA_W-1], prev_r};
    if (delta_s[DATA_W]) begin
      delta_abs_s = -delta_s;
    end else begin
      delta_abs_s = delta_s;
    end
    // Negating at DATA_W+1 bits keeps |-2^(DATA_W-1)| exact in DATA_W unsigned
    if (din_ext_s[DATA_W]) begin
      din_abs_ext_s = -din_ext_s;
    end else begin
      din_abs_ext_s = din_ext_s;
    end
    din_abs_s = din_abs_ext_s[DATA_W-1:0];
    still_s   = (delta_abs_s <= (DATA_W+1)'(STABLE_TOL));
    first_s   = (wr_count == CNT_W'(0));
    if (first_s || !still_s) begin
      run_next_s = RUN_W'(0);
    end else if (run_r == RUN_W'(STABLE_RUN)) begin
      run_next_s = run_r;
    end else begin
      run_next_s = run_r + RUN_W'(1);
    end
    reach_settle_s = (run_next_s == RUN_W'(STABLE_RUN)) && !settled;
    wr_en_s        = (state_r == ST_CAPTURE) && din_valid && !start;
    last_wr_s      = (wr_count == CNT_W'(DEPTH - 1));
  end

  // Capture state machine with all status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      wr_count     <= CNT_W'(0);
      capturing    <= 1'b0;
      capture_done <= 1'b0;
      overflow     <= 1'b0;
      settled      <= 1'b0;
      settle_idx   <= ADDR_W'(0);
      peak_abs     <= DATA_W'(0);
      prev_r       <= DATA_W'(0);
      run_r        <= RUN_W'(0);
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (start) begin
        state_r      <= ST_CAPTURE;
        wr_count     <= CNT_W'(0);
        capturing    <= 1'b1;
        capture_done <= 1'b0;
        overflow     <= 1'b0;
        settled      <= 1'b0;
        settle_idx   <= ADDR_W'(0);
        peak_abs     <= DATA_W'(0);
        run_r        <= RUN_W'(0);
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_CAPTURE: begin
            if (din_valid) begin
              wr_count <= wr_count + CNT_W'(1);
              prev_r   <= din;
              run_r    <= run_next_s;
              if (din_abs_s > peak_abs) begin
                peak_abs <= din_abs_s;
              end
              if (reach_settle_s) begin
                settled    <= 1'b1;
                settle_idx <= wr_count[ADDR_W-1:0];
              end
            end
            // A sample coincident with filter_done is written before stopping
            if (filter_done || (din_valid && last_wr_s)) begin
              state_r      <= ST_DONE;
              capturing    <= 1'b0;
              capture_done <= 1'b1;
            end
          end
          ST_DONE: begin
            if (din_valid && (wr_count == CNT_W'(DEPTH))) begin
              overflow <= 1'b1;
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            capturing <= 1'b0;
          end
        endcase
      end
    end
  end

  iir_sample_ram #(
    .W     (DATA_W),
    .DEPTH (DEPTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wr_addr (wr_count[ADDR_W-1:0]),
    .wr_data (din),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_iir_result_capture.sv
// Randomized bench for iir_result_capture against a sample-list reference model.
module tb_iir_result_capture;

  localparam int DEPTH = 2048;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic signed [23:0] din = 24'sd0;
  logic               din_valid = 1'b0;
  logic               filter_done = 1'b0;
  logic               rd_en = 1'b0;
  logic [10:0]        rd_addr = 11'd0;
  logic [11:0]        wr_count;
  logic               capturing, capture_done, overflow, settled, rd_valid;
  logic [10:0]        settle_idx;
  logic [23:0]        peak_abs, rd_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iir_result_capture dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .filter_done(filter_done), .wr_count(wr_count), .capturing(capturing),
    .capture_done(capture_done), .overflow(overflow), .settled(settled),
    .settle_idx(settle_idx), .peak_abs(peak_abs), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  // Reference: status after a capture of the given valid samples
  function automatic void model(input int s[$], output int cnt, output int peak,
                                output bit stl, output int sidx);
    int run;
    cnt = (s.size() > DEPTH) ? DEPTH : s.size();
    peak = 0; stl = 1'b0; sidx = 0; run = 0;
    for (int i = 0; i < cnt; i++) begin
      int a;
      int d;
      a = (s[i] < 0) ? -s[i] : s[i];
      if (a > peak) peak = a;
      if (i == 0) run = 0;
      else begin
        d = s[i] - s[i-1];
        if (d < 0) d = -d;
        if (d <= 64) run = (run < 16) ? run + 1 : 16;
        else run = 0;
      end
      if (!stl && run == 16) begin stl = 1'b1; sidx = i; end
    end
  endfunction

  function automatic int rand_sample();
    return int'($urandom) >>> 8;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int v, input bit valid, input bit done);
    din = v[23:0]; din_valid = valid; filter_done = done;
    tick();
    din_valid = 1'b0; filter_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic read_word(input int addr);
    rd_en = 1'b1; rd_addr = addr[10:0]; tick(); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    n_checks++;
    if ({wr_count, capturing, capture_done, overflow, settled, settle_idx, peak_abs, rd_data, rd_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got cnt=%0d cap=%b done=%b ovf=%b stl=%b sidx=%0d peak=%h rd=%h rv=%b exp all zero",
               wr_count, capturing, capture_done, overflow, settled, settle_idx, peak_abs, rd_data, rd_valid);
    end
    rst_n = 1'b1; tick();
  endtask

  task automatic test_full();
    int q[$]; int cnt, pk, sidx; bit stl; int a;
    pulse_start();
    n_checks++;
    if (capturing !== 1'b1 || wr_count !== 12'd0) begin
      n_fail++; $display("FAIL full_arm got cap=%b cnt=%0d exp cap=1 cnt=0", capturing, wr_count);
    end
    for (int i = 0; i < DEPTH; i++) q.push_back(i);
    for (int i = 0; i < DEPTH - 1; i++) drive(i, 1'b1, 1'b0);
    n_checks++;
    if (capture_done !== 1'b0 || wr_count !== 12'd2047) begin
      n_fail++; $display("FAIL full_pre got done=%b cnt=%0d exp done=0 cnt=2047", capture_done, wr_count);
    end
    drive(DEPTH - 1, 1'b1, 1'b0);
    model(q, cnt, pk, stl, sidx);
    n_checks++;
    if (wr_count !== 12'(cnt) || capture_done !== 1'b1 || overflow !== 1'b0 || capturing !== 1'b0) begin
      n_fail++; $display("FAIL full_status got cnt=%0d done=%b ovf=%b cap=%b exp cnt=%0d done=1 ovf=0 cap=0",
                         wr_count, capture_done, overflow, capturing, cnt);
    end
    n_checks++;
    if (peak_abs !== 24'(pk) || settled !== stl || settle_idx !== 11'(sidx)) begin
      n_fail++; $display("FAIL full_peak_settle got peak=%0d stl=%b sidx=%0d exp peak=%0d stl=%b sidx=%0d",
                         peak_abs, settled, settle_idx, pk, stl, sidx);
    end
    read_word(5);
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 24'd5) begin
      n_fail++; $display("FAIL full_read5 got rv=%b data=%0d exp rv=1 data=5", rd_valid, rd_data);
    end
    tick();
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_valid_pulse got %b exp 0", rd_valid);
    end
    // back-to-back reads at full rate
    rd_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      rd_addr = a[10:0];
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 24'(a)) begin
        n_fail++; $display("FAIL b2b_read addr=%0d got rv=%b data=%0d exp rv=1 data=%0d", a, rd_valid, rd_data, a);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_filter_done();
    int q[$]; int cnt, pk, sidx; bit stl; int v;
    pulse_start();
    for (int i = 0; i < 10; i++) q.push_back(rand_sample());
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) drive(rand_sample(), 1'b0, 1'b0);
      drive(q[i], 1'b1, i == 9);
    end
    model(q, cnt, pk, stl, sidx);
    n_checks++;
    if (wr_count !== 12'd10 || capture_done !== 1'b1 || capturing !== 1'b0) begin
      n_fail++; $display("FAIL fd_stop got cnt=%0d done=%b cap=%b exp cnt=10 done=1 cap=0", wr_count, capture_done, capturing);
    end
    drive(rand_sample(), 1'b1, 1'b0);
    n_checks++;
    if (wr_count !== 12'd10 || overflow !== 1'b0 || peak_abs !== 24'(pk)) begin
      n_fail++; $display("FAIL fd_extra got cnt=%0d ovf=%b peak=%0d exp cnt=10 ovf=0 peak=%0d", wr_count, overflow, peak_abs, pk);
    end
    for (int i = 0; i < 10; i++) begin
      read_word(i);
      v = q[i];
      n_checks++;
      if (rd_data !== v[23:0]) begin
        n_fail++; $display("FAIL fd_readback addr=%0d got %h exp %h", i, rd_data, v[23:0]);
      end
    end
  endtask

  task automatic test_overflow();
    int q[$]; int cnt, pk, sidx; bit stl; int v;
    pulse_start();
    for (int i = 0; i <= DEPTH; i++) q.push_back(rand_sample());
    for (int i = 0; i < DEPTH; i++) drive(q[i], 1'b1, 1'b0);
    n_checks++;
    if (overflow !== 1'b0 || capture_done !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pre got ovf=%b done=%b exp ovf=0 done=1", overflow, capture_done);
    end
    drive(q[DEPTH], 1'b1, 1'b0);
    model(q, cnt, pk, stl, sidx);
    n_checks++;
    if (overflow !== 1'b1 || wr_count !== 12'd2048 || peak_abs !== 24'(pk)) begin
      n_fail++; $display("FAIL ovf_status got ovf=%b cnt=%0d peak=%0d exp ovf=1 cnt=2048 peak=%0d", overflow, wr_count, peak_abs, pk);
    end
    read_word(0);
    v = q[0];
    n_checks++;
    if (rd_data !== v[23:0]) begin
      n_fail++; $display("FAIL ovf_addr0 got %h exp %h", rd_data, v[23:0]);
    end
  endtask

  task automatic test_settle();
    int q[$]; int cnt, pk, sidx; bit stl; int v; int n;
    pulse_start();
    for (int i = 0; i < 3; i++) q.push_back(32'h100000);
    for (int i = 0; i < 20; i++) q.push_back((i % 2 == 0) ? 32'h200000 : 32'h200030);
    for (int i = 0; i < 19; i++) drive(q[i], 1'b1, 1'b0);
    n_checks++;
    if (settled !== 1'b0) begin
      n_fail++; $display("FAIL settle_early got stl=%b exp 0", settled);
    end
    for (int i = 19; i < 23; i++) drive(q[i], 1'b1, 1'b0);
    n_checks++;
    if (settled !== 1'b1 || settle_idx !== 11'd19) begin
      n_fail++; $display("FAIL settle_directed got stl=%b sidx=%0d exp stl=1 sidx=19", settled, settle_idx);
    end
    // random walks with a mix of small and large steps
    for (int r = 0; r < 3; r++) begin
      q.delete();
      n = $urandom_range(30, 200);
      v = int'($urandom_range(0, 32'h200000)) - 32'h100000;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) v = v + int'($urandom_range(0, 2000)) - 1000;
        else v = v + int'($urandom_range(0, 140)) - 70;
        q.push_back(v);
      end
      pulse_start();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) drive(rand_sample(), 1'b0, 1'b0);
        drive(q[i], 1'b1, 1'b0);
      end
      drive(0, 1'b0, 1'b1);
      model(q, cnt, pk, stl, sidx);
      n_checks++;
      if (wr_count !== 12'(cnt) || capture_done !== 1'b1 || peak_abs !== 24'(pk) ||
          settled !== stl || settle_idx !== 11'(sidx)) begin
        n_fail++; $display("FAIL settle_random got cnt=%0d done=%b peak=%0d stl=%b sidx=%0d exp cnt=%0d done=1 peak=%0d stl=%b sidx=%0d",
                           wr_count, capture_done, peak_abs, settled, settle_idx, cnt, pk, stl, sidx);
      end
    end
  endtask

  task automatic test_peak();
    pulse_start();
    drive(32'h100000, 1'b1, 1'b0);
    n_checks++;
    if (peak_abs !== 24'h100000) begin
      n_fail++; $display("FAIL peak_first got %h exp 100000", peak_abs);
    end
    drive(-8388608, 1'b1, 1'b0);
    drive(-5, 1'b1, 1'b0);
    n_checks++;
    if (peak_abs !== 24'h800000 || wr_count !== 12'd3) begin
      n_fail++; $display("FAIL peak_minneg got peak=%h cnt=%0d exp peak=800000 cnt=3", peak_abs, wr_count);
    end
  endtask

  task automatic test_restart();
    int v;
    pulse_start();
    for (int i = 0; i < 5; i++) drive(rand_sample(), 1'b1, 1'b0);
    start = 1'b1; din = 24'sh123; din_valid = 1'b1;
    tick();
    start = 1'b0; din_valid = 1'b0;
    n_checks++;
    if (wr_count !== 12'd0 || capturing !== 1'b1 || capture_done !== 1'b0 || peak_abs !== 24'd0) begin
      n_fail++; $display("FAIL restart_clear got cnt=%0d cap=%b done=%b peak=%0d exp cnt=0 cap=1 done=0 peak=0",
                         wr_count, capturing, capture_done, peak_abs);
    end
    v = rand_sample();
    drive(v, 1'b1, 1'b0);
    drive(rand_sample(), 1'b1, 1'b0);
    read_word(0);
    n_checks++;
    if (wr_count !== 12'd2 || rd_data !== v[23:0]) begin
      n_fail++; $display("FAIL restart_idx0 got cnt=%0d data=%h exp cnt=2 data=%h", wr_count, rd_data, v[23:0]);
    end
  endtask

  task automatic test_reset_mid();
    int q[$]; int v;
    pulse_start();
    for (int i = 0; i < 100; i++) q.push_back(rand_sample());
    for (int i = 0; i < 100; i++) drive(q[i], 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (wr_count !== 12'd0 || capturing !== 1'b0 || peak_abs !== 24'd0 || settled !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort got cnt=%0d cap=%b peak=%0d stl=%b exp all zero", wr_count, capturing, peak_abs, settled);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    n_checks++;
    if (wr_count !== 12'd0 || capturing !== 1'b1 || capture_done !== 1'b0 || overflow !== 1'b0 ||
        settled !== 1'b0 || settle_idx !== 11'd0 || peak_abs !== 24'd0) begin
      n_fail++; $display("FAIL reset_restart got cnt=%0d cap=%b done=%b ovf=%b stl=%b sidx=%0d peak=%0d exp cnt=0 cap=1 rest 0",
                         wr_count, capturing, capture_done, overflow, settled, settle_idx, peak_abs);
    end
    v = rand_sample();
    drive(v, 1'b1, 1'b0);
    read_word(0);
    n_checks++;
    if (rd_data !== v[23:0] || wr_count !== 12'd1) begin
      n_fail++; $display("FAIL reset_new0 got data=%h cnt=%0d exp data=%h cnt=1", rd_data, wr_count, v[23:0]);
    end
    read_word(1);
    v = q[1];
    n_checks++;
    if (rd_data !== v[23:0]) begin
      n_fail++; $display("FAIL reset_keep1 got %h exp %h", rd_data, v[23:0]);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_filter_done();
    test_overflow();
    test_settle();
    test_peak();
    test_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_result_capture.md
# iir_result_capture

Downstream consumer of the IIR filter top-level output stream. Accepts Q2.22 `data_out`/`data_out_valid` samples into a 2048-entry on-chip buffer indexed by sample number and tracks the running peak magnitude. It also detects when the filter output has settled and exposes the buffer through a synchronous read port for host or debug readback after capture. Each capture is armed by the same `start` pulse that launches the filter and ends on the filter's `filter_done` or on buffer full.

## Interface
Parameters:
- `DATA_W`, 24: sample width, signed Q2.22.
- `DEPTH`, 2048: buffer entries.
- `ADDR_W`, 11: log2(DEPTH).
- `STABLE_TOL`, 64: max |Δ| between consecutive samples, in LSBs, counted as "still".
- `STABLE_RUN`, 16: consecutive still samples required to declare settled.

Ports:
- Clock and reset: single clock `clk`; reset `rst_n`, asynchronous, active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  async active-low reset.
- `start`  in  1  one-cycle arm pulse; clears all status.
- `din`  in  DATA_W  filter output sample, signed.
- `din_valid`  in  1  `din` qualifier.
- `filter_done`  in  1  end-of-run pulse from the filter.
- `wr_count`  out  ADDR_W+1  samples captured so far (0..DEPTH).
- `capturing`  out  1  high in CAPTURE state.
- `capture_done`  out  1  sticky until next `start`.
- `overflow`  out  1  sticky; valid sample arrived while buffer full.
- `settled`  out  1  sticky; stability criterion met.
- `settle_idx`  out  ADDR_W  index of the sample that completed the still run.
- `peak_abs`  out  DATA_W  max |din| over captured samples, unsigned.
- `rd_en`  in  1  read request.
- `rd_addr`  in  ADDR_W  read index.
- `rd_data`  out  DATA_W  read data.
- `rd_valid`  out  1  qualifies `rd_data`.

## Operation
- **States**:
  - IDLE (reset state).
  - CAPTURE.
  - DONE.
- **Transitions**:
  - `start` in any state clears `wr_count`, status, run counter and peak, then moves to CAPTURE.
  - `din` on the `start` cycle is discarded.
  - CAPTURE→DONE when `filter_done` is seen or `wr_count` reaches DEPTH.
  - DONE holds until the next `start`.
- **Write path**:
  - In CAPTURE, each `din_valid` writes `din` at address `wr_count[ADDR_W-1:0]` and increments `wr_count`.
  - `din_valid` together with `filter_done` captures that sample first, then enters DONE.
  - `din_valid` in DONE or IDLE is ignored.
  - In DONE, `overflow` is set only if DONE was reached by full.
- **Peak**:
  - `peak_abs` = max(|din|) over captured samples.
  - |−2^23| = 2^23, which is representable in DATA_W unsigned.
- **Stability**:
  - Δ = din − prev, computed at DATA_W+1 bits signed.
  - The first captured sample has no prev and resets the run counter.
  - If |Δ| ≤ STABLE_TOL, the run counter increments, saturating at STABLE_RUN; otherwise it clears.
  - When the counter first reaches STABLE_RUN, set `settled` and latch `settle_idx` = index of that sample.
  - Later runs do not update `settle_idx`.
- **Readback**:
  - Reads are allowed in any state.
  - A read of the address being written on the same cycle returns the old contents.

## Timing
- Reset values:
  - State IDLE.
  - `wr_count` = 0.
  - `capturing`, `capture_done`, `overflow`, `settled`, `rd_valid` = 0.
  - `settle_idx` = 0, `peak_abs` = 0.
  - `rd_data` = 0.
  - Buffer contents are undefined.
- `capturing` rises the cycle after `start`.
- Write, `wr_count`, `peak_abs` and `settled` are all updated at the clock edge where `din_valid` is sampled, visible the next cycle.
- `capture_done` rises the cycle after the terminating `filter_done` or the DEPTH-th write.
- Read latency is 1 cycle: `rd_en`/`rd_addr` at edge N gives `rd_data`/`rd_valid` after edge N. `rd_valid` is a one-cycle pulse per request; back-to-back reads run at full rate.
- Reset asserted mid-capture aborts immediately to IDLE; buffer contents are not cleared.
- `start` mid-capture restarts from index 0.

## Structure
- **Shared package `iir_pkg`**:
  - `SAMPLE_W` = 24, `FRAC_W` = 22, `N_SAMPLES` = 2048, `IDX_W` = 11.
  - Sample typedef (signed 24-bit).
  - Capture state enum.
- **Sub-module `iir_sample_ram`**:
  - Simple dual-port: 1 write port, 1 registered read port.
  - Parameterized by width and depth, inferable as block RAM.
- All state, stability and peak logic lives in the top.

## Test plan
- Reset, `start`, then 2048 valid samples with `din` = index → `wr_count` = 2048, `capture_done` = 1, `overflow` = 0; reading addr 5 returns 5 one cycle later.
- 10 samples, then `filter_done` coincident with the 10th → `wr_count` = 10, `capture_done` the next cycle; an 11th `din_valid` leaves `wr_count` = 10.
- 2049 valid samples → `overflow` = 1, `wr_count` = 2048, addr 0 still holds the first sample.
- Samples 0x100000 ×3, then 20 samples alternating 0x200000/0x200030 → `settled` = 1, `settle_idx` = 19 (16th still sample).
- Samples +0x100000, 0x800000 (−2^23), −5 → `peak_abs` = 0x800000.
- Reset asserted after 100 samples of a capture, then `start` → `wr_count` = 0, all status cleared, capture restarts at index 0.
